// File: rtl/toggle_scheduler_pkg.sv
// Shared types and default geometry for the toggle scheduler.
// The event-entry struct is sized by the defaults here, so top parameters must match them.
package toggle_scheduler_pkg;

  localparam int IDX_W       = 3;
  localparam int PKG_NUM_EVT = 1 << IDX_W;
  localparam int PKG_DLY_W   = 16;
  localparam int PKG_NUM_OUT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  typedef struct packed {
    logic [PKG_DLY_W-1:0]   dly;
    logic [PKG_NUM_OUT-1:0] mask;
  } evt_t;

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter; expire is high in the last cycle of a loaded interval.
// A load of 0 is clamped to 1, so expiry lands exactly max(val,1) edges after the load.
module tick_timer #(
  parameter int DLY_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DLY_W-1:0] load_val,
  input  logic             run,
  output logic             expire
);

  logic [DLY_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (load_val == '0) ? DLY_W'(1) : load_val;
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = run && (cnt == DLY_W'(1));

endmodule

// File: rtl/toggle_scheduler.sv
// Table-driven sequencer: XORs per-event masks into out_q at programmed cycle delays.
// First event fires max(dly[0],1) edges after start; done is registered one edge after FIN.
module toggle_scheduler
  import toggle_scheduler_pkg::*;
#(
  parameter int NUM_EVT = PKG_NUM_EVT,
  parameter int DLY_W   = PKG_DLY_W,
  parameter int NUM_OUT = PKG_NUM_OUT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [$clog2(NUM_EVT)-1:0] cfg_addr,
  input  logic [DLY_W-1:0]           cfg_dly,
  input  logic [NUM_OUT-1:0]         cfg_mask,
  input  logic [$clog2(NUM_EVT):0]   cfg_len,
  input  logic                       cfg_loop,
  output logic                       cfg_rej,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       out_clr,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(NUM_EVT)-1:0] evt_idx,
  output logic [NUM_OUT-1:0]         out_q
);

  localparam int IW = $clog2(NUM_EVT);

  state_t             state_q, state_d;
  evt_t               table_q [NUM_EVT];
  logic [IW-1:0]      idx_d;
  logic [IW-1:0]      last_q, last_d;
  logic               loop_q;
  logic [NUM_OUT-1:0] out_d;
  logic               accept;
  logic [IW:0]        len_c;
  logic               ld;
  logic [DLY_W-1:0]   ld_val;
  logic               tmr_run;
  logic               expire;

  // Lengths beyond the table size are clamped to the whole table.
  assign len_c   = (cfg_len > (IW+1)'(NUM_EVT)) ? (IW+1)'(NUM_EVT) : cfg_len;
  assign last_d  = IW'(len_c - 1'b1);
  assign tmr_run = (state_q == RUN);
  assign busy    = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    idx_d   = evt_idx;
    out_d   = out_q;
    accept  = 1'b0;
    ld      = 1'b0;
    ld_val  = table_q[0].dly;
    case (state_q)
      IDLE: begin
        if (out_clr) out_d = '0;
        if (start && !abort) begin
          accept = 1'b1;
          if (cfg_len == '0) begin
            state_d = FIN;
          end else begin
            state_d = RUN;
            idx_d   = '0;
            ld      = 1'b1;
          end
        end
      end
      RUN: begin
        // Abort outranks an event expiring in the same cycle.
        if (abort) begin
          state_d = IDLE;
        end else if (expire) begin
          out_d = out_q ^ table_q[evt_idx].mask;
          if (evt_idx != last_q) begin
            idx_d  = evt_idx + 1'b1;
            ld     = 1'b1;
            ld_val = table_q[evt_idx + 1'b1].dly;
          end else if (loop_q) begin
            idx_d = '0;
            ld    = 1'b1;
          end else begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      evt_idx <= '0;
      out_q   <= '0;
      done    <= 1'b0;
      cfg_rej <= 1'b0;
      last_q  <= '0;
      loop_q  <= 1'b0;
      for (int i = 0; i < NUM_EVT; i++) begin
        table_q[i] <= evt_t'{dly: PKG_DLY_W'(1), mask: '0};
      end
    end else begin
      state_q <= state_d;
      evt_idx <= idx_d;
      out_q   <= out_d;
      done    <= (state_q == FIN);
      cfg_rej <= cfg_we && (state_q == RUN);
      if (accept) begin
        last_q <= last_d;
        loop_q <= cfg_loop;
      end
      if (cfg_we && (state_q != RUN)) begin
        table_q[cfg_addr] <= evt_t'{dly: cfg_dly, mask: cfg_mask};
      end
    end
  end

  tick_timer #(
    .DLY_W(DLY_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (ld),
    .load_val(ld_val),
    .run     (tmr_run),
    .expire  (expire)
  );

endmodule

// File: tb/tb_toggle_scheduler.sv
// Scenario bench for toggle_scheduler; a schedule model derives fire times from delay sums.
module tb_toggle_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [15:0] cfg_dly = '0;
  logic [3:0]  cfg_mask = '0;
  logic [3:0]  cfg_len = '0;
  logic        cfg_loop = 1'b0;
  logic        cfg_rej;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        out_clr = 1'b0;
  logic        busy;
  logic        done;
  logic [2:0]  evt_idx;
  logic [3:0]  out_q;

  int          errors = 0;
  int          checks = 0;
  int          m_dly [8];
  logic [3:0]  m_mask [8];
  logic [3:0]  model_out = '0;

  always #5 clk = ~clk;

  toggle_scheduler dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_we  (cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_dly (cfg_dly),
    .cfg_mask(cfg_mask),
    .cfg_len (cfg_len),
    .cfg_loop(cfg_loop),
    .cfg_rej (cfg_rej),
    .start   (start),
    .abort   (abort),
    .out_clr (out_clr),
    .busy    (busy),
    .done    (done),
    .evt_idx (evt_idx),
    .out_q   (out_q)
  );

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_dly[i]  = 1;
      m_mask[i] = '0;
    end
    model_out = '0;
  endtask

  // Idle-time table write; caller sits just after a rising edge.
  task automatic cfg_write(input int a, input int d, input logic [3:0] m);
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_dly = 16'(d); cfg_mask = m;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_dly[a] = d; m_mask[a] = m;
    checks++;
    if (cfg_rej !== 1'b0) begin
      errors++; $display("FAIL idle_write_rej: cfg_rej=%b expected 0", cfg_rej);
    end
  endtask

  // Start a sequence at the next edge (T) and compare every cycle against the schedule.
  // abort_cyc / we_cyc: edge offset from T at which abort / a rejected write is sampled (0/-1 = none).
  task automatic run_seq(input string name, input int len, input bit lp, input int abort_cyc,
                         input int we_cyc, input bit clr);
    int ft[$];
    logic [3:0] fm[$];
    int t, k, fin, busy_end, done_at, horizon, n;
    bit aborted;
    logic [3:0] exp_out;
    logic [2:0] exp_idx;
    t = 0; k = 0; fin = -1;
    if (lp && len > 0 && abort_cyc == 0) abort_cyc = 50;
    if (clr) model_out = '0;
    if (len == 0) fin = 0;
    else begin
      while (1) begin
        t += (m_dly[k] == 0) ? 1 : m_dly[k];
        if (abort_cyc > 0 && t >= abort_cyc) break;
        ft.push_back(t); fm.push_back(m_mask[k]);
        k++;
        if (k == len) begin
          if (!lp) begin fin = t; break; end
          k = 0;
        end
      end
    end
    aborted  = (len > 0) && (fin < 0);
    busy_end = aborted ? abort_cyc : fin;
    done_at  = aborted ? -1 : fin + 1;
    horizon  = aborted ? abort_cyc + 6 : fin + 3;

    start = 1'b1; out_clr = clr; cfg_len = 4'(len); cfg_loop = lp;
    for (int c = 0; c <= horizon; c++) begin
      @(posedge clk); #1;
      start = 1'b0; out_clr = 1'b0;
      exp_out = model_out; n = 0;
      foreach (ft[i]) if (ft[i] <= c) begin exp_out ^= fm[i]; n++; end
      checks++;
      if (out_q !== exp_out) begin
        errors++; $display("FAIL %s out_q T+%0d: got %b expected %b", name, c, out_q, exp_out);
      end
      checks++;
      if (busy !== 1'(c < busy_end)) begin
        errors++; $display("FAIL %s busy T+%0d: got %b expected %b", name, c, busy, c < busy_end);
      end
      checks++;
      if (done !== 1'(c == done_at)) begin
        errors++; $display("FAIL %s done T+%0d: got %b expected %b", name, c, done, c == done_at);
      end
      checks++;
      if (cfg_rej !== 1'(we_cyc > 0 && c == we_cyc)) begin
        errors++; $display("FAIL %s cfg_rej T+%0d: got %b expected %b", name, c, cfg_rej,
                           we_cyc > 0 && c == we_cyc);
      end
      if (c < busy_end) begin
        exp_idx = lp ? 3'(n % len) : 3'(n);
        checks++;
        if (evt_idx !== exp_idx) begin
          errors++; $display("FAIL %s evt_idx T+%0d: got %0d expected %0d", name, c, evt_idx, exp_idx);
        end
      end
      abort  = (c + 1 == abort_cyc);
      cfg_we = (we_cyc > 0 && c + 1 == we_cyc);
      if (cfg_we) begin
        cfg_addr = 3'($urandom_range(0, 1));
        cfg_dly  = 16'($urandom_range(7, 30));
        cfg_mask = 4'($urandom);
      end
    end
    abort = 1'b0; cfg_we = 1'b0;
    foreach (fm[i]) model_out ^= fm[i];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({out_q, busy, done, cfg_rej, evt_idx} !== 10'b0) begin
      errors++; $display("FAIL reset_values: out_q=%b busy=%b done=%b rej=%b idx=%0d expected all 0",
                         out_q, busy, done, cfg_rej, evt_idx);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_basic();
    cfg_write(0, 10, 4'b0001);
    cfg_write(1, 20, 4'b0010);
    cfg_write(2, 10, 4'b0001);
    run_seq("basic", 3, 1'b0, 0, -1, 1'b0);
    checks++;
    if (out_q !== 4'b0010) begin
      errors++; $display("FAIL basic_final: out_q=%b expected 0010", out_q);
    end
  endtask

  task automatic test_zero_delay();
    cfg_write(0, 0, 4'b1111);
    run_seq("zero_dly", 1, 1'b0, 0, -1, 1'b0);
  endtask

  task automatic test_loop_abort();
    cfg_write(0, 5, 4'b0001);
    cfg_write(1, 5, 4'b0001);
    run_seq("loop_abort", 2, 1'b1, 18, -1, 1'b0);
  endtask

  task automatic test_abort_on_fire();
    cfg_write(0, 4, 4'b0100);
    cfg_write(1, 4, 4'b1000);
    run_seq("abort_fire", 2, 1'b0, 8, -1, 1'b0);
  endtask

  task automatic test_busy_write();
    cfg_write(0, 3, 4'b0101);
    cfg_write(1, 4, 4'b1000);
    run_seq("rej_run", 2, 1'b0, 0, 2, 1'b0);
    run_seq("rej_rerun", 2, 1'b0, 0, -1, 1'b0);
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1; abort = 1'b1; cfg_len = 4'd2; cfg_loop = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || out_q !== model_out) begin
        errors++; $display("FAIL start_abort_idle c%0d: busy=%b done=%b out_q=%b expected 0 0 %b",
                           c, busy, done, out_q, model_out);
      end
    end
  endtask

  task automatic test_len_zero();
    run_seq("len0", 0, 1'b0, 0, -1, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    cfg_write(0, 3, 4'b1111);
    cfg_write(1, 50, 4'b0000);
    start = 1'b1; cfg_len = 4'd2; cfg_loop = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    checks++;
    if (out_q !== (model_out ^ 4'b1111) || busy !== 1'b1) begin
      errors++; $display("FAIL pre_reset: out_q=%b busy=%b expected %b 1", out_q, busy, model_out ^ 4'b1111);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_q !== 4'b0 || busy !== 1'b0 || evt_idx !== 3'd0) begin
      errors++; $display("FAIL async_reset: out_q=%b busy=%b idx=%0d expected 0 0 0", out_q, busy, evt_idx);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    run_seq("post_reset_table", 2, 1'b0, 0, -1, 1'b0);
  endtask

  task automatic test_out_clr();
    cfg_write(0, 2, 4'b0110);
    run_seq("pre_clr", 1, 1'b0, 0, -1, 1'b0);
    out_clr = 1'b1;
    @(posedge clk); #1;
    out_clr = 1'b0;
    model_out = '0;
    checks++;
    if (out_q !== 4'b0) begin
      errors++; $display("FAIL out_clr: out_q=%b expected 0000", out_q);
    end
    cfg_write(0, 2, 4'b1001);
    run_seq("clr_start_pre", 1, 1'b0, 0, -1, 1'b0);
    run_seq("clr_with_start", 1, 1'b0, 0, -1, 1'b1);
  endtask

  task automatic test_random();
    int len, tot, ab, be, we;
    bit lp;
    for (int it = 0; it < 10; it++) begin
      for (int k = 0; k < 8; k++) cfg_write(k, $urandom_range(0, 5), 4'($urandom));
      len = $urandom_range(0, 8);
      lp  = 1'($urandom_range(0, 1));
      tot = 0;
      for (int k = 0; k < len; k++) tot += (m_dly[k] == 0) ? 1 : m_dly[k];
      ab = 0;
      if (len > 0) begin
        if (lp) ab = $urandom_range(1, tot * 2 + 2);
        else if ($urandom_range(0, 2) == 0) ab = $urandom_range(1, tot);
      end
      be = (len == 0) ? 0 : ((ab > 0) ? ab : tot);
      we = (be >= 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, be) : -1;
      run_seq("random", len, lp, ab, we, 1'($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_delay();
    test_loop_abort();
    test_abort_on_fire();
    test_busy_write();
    test_start_abort_idle();
    test_len_zero();
    test_reset_mid_run();
    test_out_clr();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
